// File: rtl/cpu_ctrl_pkg.sv
// Control-word bit positions, the quiescent control word and the loader state
// encoding shared by the loader and the CPU top level.
package cpu_ctrl_pkg;

  localparam int CP   = 14;
  localparam int EP   = 13;
  localparam int LP   = 12;
  localparam int NLMA = 11;
  localparam int NLMD = 10;
  localparam int NCE  = 9;
  localparam int NLR  = 8;
  localparam int NLI  = 7;
  localparam int NEI  = 6;
  localparam int NLA  = 5;
  localparam int EA   = 4;
  localparam int SUB  = 3;
  localparam int EU   = 2;
  localparam int NLB  = 1;
  localparam int NLO  = 0;

  // Active-low strobes high, active-high strobes low: nothing happens.
  localparam logic [14:0] IDLE_WORD = 15'h0FE3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } ld_state_t;

  function automatic logic [14:0] strobe_low(input int idx);
    return IDLE_WORD & ~(15'd1 << idx);
  endfunction

endpackage

// File: rtl/loader_ctrl_mux.sv
// Selects the control word and bus byte for the datapath: CPU word when the
// loader is idle, otherwise a loader word with a single active strobe.
module loader_ctrl_mux
  import cpu_ctrl_pkg::*;
(
  input  logic        pass_through,
  input  logic        is_addr,
  input  logic        is_data,
  input  logic        is_write,
  input  logic [14:0] ctrl_in,
  input  logic [7:0]  addr_byte,
  input  logic [7:0]  data_q,
  output logic [14:0] ctrl_out,
  output logic [7:0]  bus_out,
  output logic        bus_oe
);

  always_comb begin
    ctrl_out = IDLE_WORD;
    bus_out  = 8'h00;
    bus_oe   = 1'b0;
    if (pass_through) begin
      ctrl_out = ctrl_in;
    end else if (is_addr) begin
      ctrl_out = strobe_low(NLMA);
      bus_out  = addr_byte;
      bus_oe   = 1'b1;
    end else if (is_data) begin
      ctrl_out = strobe_low(NLMD);
      bus_out  = data_q;
      bus_oe   = 1'b1;
    end else if (is_write) begin
      // nCE stays high from IDLE_WORD, so RAM is written and not read onto the bus.
      ctrl_out = strobe_low(NLR);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte loader that takes over the CPU bus, MAR and RAM while holding the CPU in
// reset, writing consecutive bytes from address 0.
//
// state      | meaning
// IDLE       | CPU owns the datapath, ctrl_in passed through
// WAIT_BYTE  | ld_ready high, waiting for the next loader byte
// ADDR       | drive addr on bus, latch MAR
// DATA       | drive captured byte on bus, latch MDR
// WRITE      | write RAM, advance address or finish
// DONE       | one-cycle load_done pulse, CPU still in reset
module program_loader
  import cpu_ctrl_pkg::*;
#(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [14:0]       ctrl_in,
  output logic [14:0]       ctrl_out,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  ld_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      byte_count <= '0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_load) begin
            state      <= ST_WAIT_BYTE;
            addr       <= '0;
            byte_count <= '0;
          end
        end
        ST_WAIT_BYTE: begin
          if (ld_valid) begin
            data_q <= ld_data;
            last_q <= ld_last;
            state  <= ST_ADDR;
          end
        end
        ST_ADDR:  state <= ST_DATA;
        ST_DATA:  state <= ST_WRITE;
        ST_WRITE: begin
          byte_count <= byte_count + 1'b1;
          if (last_q || addr == LAST_ADDR) begin
            state <= ST_DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= ST_WAIT_BYTE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign ld_ready  = (state == ST_WAIT_BYTE);
  assign load_done = (state == ST_DONE);
  assign cpu_rst_n = rst_n & ~busy;

  // The rst_n term keeps ctrl_out quiescent while reset is asserted.
  loader_ctrl_mux u_mux (
    .pass_through (rst_n && (state == ST_IDLE)),
    .is_addr      (state == ST_ADDR),
    .is_data      (state == ST_DATA),
    .is_write     (state == ST_WRITE),
    .ctrl_in      (ctrl_in),
    .addr_byte    (8'(addr)),
    .data_q       (data_q),
    .ctrl_out     (ctrl_out),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe)
  );

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a small MAR/MDR/RAM model driven by the
// control word, and an expected-RAM image built from the bytes each load offers.
module tb_program_loader;

  localparam logic [14:0] W_IDLE  = 15'h0FE3;
  localparam logic [14:0] W_ADDR  = 15'h07E3;
  localparam logic [14:0] W_DATA  = 15'h0BE3;
  localparam logic [14:0] W_WRITE = 15'h0EE3;
  localparam logic [14:0] CPU_SAFE = 15'h0D00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic [14:0] ctrl_in;
  logic [14:0] ctrl_out;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        cpu_rst_n;
  logic        busy;
  logic        load_done;
  logic [4:0]  byte_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [3:0] mar = 4'h0;
  logic [7:0] mdr = 8'h00;
  logic [7:0] ram [16];
  logic [7:0] exp_ram [16];
  logic [7:0] load_buf [16];

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ctrl_in    (ctrl_in),
    .ctrl_out   (ctrl_out),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .load_done  (load_done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Datapath seen by the loader: MAR, MDR and RAM react to the control word.
  always @(posedge clk) begin
    if (busy) begin
      if (!ctrl_out[11]) mar <= bus_out[3:0];
      if (!ctrl_out[10]) mdr <= bus_out;
      if (!ctrl_out[8])  ram[mar] <= mdr;
    end
  end

  always @(negedge clk) if (load_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), ram[i], exp_ram[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int idx);
    int waited = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ld_data = b; ld_last = last; ld_valid = 1'b1;
    while (!ld_ready && waited < 50) begin @(negedge clk); waited++; end
    chk("ready_wait", 32'(waited < 50), 1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'($urandom);
    ctrl_in = 15'($urandom) | CPU_SAFE;
    chk("addr_word", ctrl_out, W_ADDR);
    chk("addr_oe", bus_oe, 1);
    chk("addr_bus", bus_out, idx);
    @(negedge clk);
    chk("data_word", ctrl_out, W_DATA);
    chk("data_oe", bus_oe, 1);
    chk("data_bus", bus_out, b);
    @(negedge clk);
    chk("write_word", ctrl_out, W_WRITE);
    chk("write_oe", bus_oe, 0);
    chk("write_cpu_rst", cpu_rst_n, 0);
  endtask

  // Offers n bytes of load_buf; ends at the first negedge after DONE.
  task automatic run_load(input int n, input bit use_last, input bit hold_start,
                          input bit started);
    int d0 = done_cnt;
    int nw = (n > 16) ? 16 : n;
    if (!started) begin
      start_load = 1'b1;
      @(negedge clk);
      if (!hold_start) start_load = 1'b0;
    end
    chk("start_busy", busy, 1);
    chk("start_count", byte_count, 0);
    for (int i = 0; i < nw; i++) send_byte(load_buf[i], use_last && (i == n - 1), i);
    @(negedge clk);
    chk("done_pulse", load_done, 1);
    chk("done_busy", busy, 1);
    chk("done_cpu_rst", cpu_rst_n, 0);
    for (int i = 0; i < nw; i++) exp_ram[i] = load_buf[i];
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_cpu_rst", cpu_rst_n, 1);
    chk("after_pass", ctrl_out, ctrl_in);
    chk("after_count", byte_count, nw);
    chk("done_once", done_cnt - d0, 1);
    chk_ram("ram");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ram[i] = 8'h00; exp_ram[i] = 8'h00; end
    rst_n = 1'b0; start_load = 1'b0; ld_data = 8'h00; ld_valid = 1'b0; ld_last = 1'b0;
    ctrl_in = 15'h5A5A;
    #12;
    chk("rst_ctrl", ctrl_out, W_IDLE);
    chk("rst_cpu_rst", cpu_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_done", load_done, 0);
    chk("rst_count", byte_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pass", ctrl_out, 15'h5A5A);
    chk("idle_busy", busy, 0);
    chk("idle_cpu_rst", cpu_rst_n, 1);
    ctrl_in = 15'h7FFF;

    // ld_valid in IDLE is ignored
    ld_valid = 1'b1; ld_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_noready", ld_ready, 0);
    chk("idle_nobusy", busy, 0);
    ld_valid = 1'b0;

    load_buf[0] = 8'h1E; load_buf[1] = 8'h2F; load_buf[2] = 8'hE0;
    run_load(3, 1, 0, 0);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) load_buf[i] = 8'($urandom);
      run_load(n, 1, 0, 0);
    end

    // Full load without ld_last, then a 17th byte must not be accepted
    for (int i = 0; i < 16; i++) load_buf[i] = 8'($urandom);
    run_load(16, 0, 0, 0);
    ld_valid = 1'b1; ld_data = 8'h55;
    repeat (5) @(negedge clk);
    chk("extra_ready", ld_ready, 0);
    chk("extra_busy", busy, 0);
    chk("extra_count", byte_count, 16);
    ld_valid = 1'b0;
    chk_ram("ram_extra");

    // start_load held through DONE re-arms on the cycle after IDLE
    load_buf[0] = 8'($urandom); load_buf[1] = 8'($urandom);
    run_load(2, 1, 1, 0);
    @(negedge clk);
    start_load = 1'b0;
    chk("rearm_busy", busy, 1);
    chk("rearm_ready", ld_ready, 1);
    chk("rearm_count", byte_count, 0);
    load_buf[0] = 8'($urandom);
    run_load(1, 1, 0, 1);

    // Stalled loader
    start_load = 1'b1; @(negedge clk); start_load = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_ctrl", ctrl_out, W_IDLE);
    chk("stall_oe", bus_oe, 0);
    chk("stall_ready", ld_ready, 1);
    chk("stall_busy", busy, 1);
    chk("stall_cpu_rst", cpu_rst_n, 0);

    // start_load mid-load ignored, then reset during DATA
    load_buf[0] = 8'($urandom);
    load_buf[1] = ~exp_ram[1];
    send_byte(load_buf[0], 0, 0);
    exp_ram[0] = load_buf[0];
    @(negedge clk);
    start_load = 1'b1; @(negedge clk); start_load = 1'b0;
    @(negedge clk);
    chk("mid_start_count", byte_count, 1);
    chk("mid_start_busy", busy, 1);
    chk("mid_start_ready", ld_ready, 1);
    ld_data = load_buf[1]; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0;
    @(negedge clk);
    chk("mid_data_word", ctrl_out, W_DATA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", ctrl_out, W_IDLE);
    chk("mid_rst_oe", bus_oe, 0);
    chk("mid_rst_bus", bus_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu", cpu_rst_n, 0);
    chk("mid_rst_count", byte_count, 0);
    chk("mid_rst_ready", ld_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk_ram("ram_rst");

    // Recovery load after the interrupted one
    for (int i = 0; i < 16; i++) load_buf[i] = 8'($urandom);
    run_load(5, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Arbiter/sequencer that shares the CPU bus, MAR and RAM between an external byte loader and the normal `control_block` microsequence.
- Outside a load it passes the CPU control word through unchanged.
- During a load it holds the CPU in reset and drives its own control words and bus bytes, writing consecutive bytes into RAM from address 0.
- It sits between `control_block.out` and the 15-bit control bus in the top level.

Parameters:
- RAM_BYTES, 16, number of RAM locations; the load ends automatically after the last one.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= RAM_BYTES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_load  input  1  pulse or level; a load begins when seen in IDLE
- ld_data  input  8  byte offered by the loader
- ld_valid  input  1  ld_data is valid
- ld_last  input  1  qualifies the current byte as the final one
- ld_ready  output  1  loader may present a byte; a transfer occurs when ld_valid & ld_ready
- ctrl_in  input  15  control word from `control_block` (Cp..nLo, bit 14..0)
- ctrl_out  output  15  control word driven to the datapath
- bus_out  output  8  byte the loader drives onto the bus
- bus_oe  output  1  loader drives the bus this cycle
- cpu_rst_n  output  1  gated reset to PC, IR, `control_block` and A; equals rst_n & ~busy
- busy  output  1  a load is in progress
- load_done  output  1  one-cycle pulse when a load completes
- byte_count  output  ADDR_W+1  bytes written in the current or last load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, addr=0, byte_count=0, data_q=0.
  - ld_ready=0, bus_oe=0, bus_out=0, busy=0, load_done=0.
  - ctrl_out=IDLE_WORD=15'h0FE3 (all active-low strobes high, all active-high strobes low).
  - cpu_rst_n=0.
- ctrl_out: equals ctrl_in combinationally in IDLE; otherwise it is the state's loader word, with every bit not listed at its IDLE_WORD value.
- IDLE: busy=0.
  - start_load=1 -> WAIT_BYTE, addr=0, byte_count=0.
- WAIT_BYTE: ld_ready=1, ctrl_out=IDLE_WORD.
  - On ld_valid: capture ld_data into data_q and ld_last into last_q, then go to ADDR.
  - Without ld_valid: hold, with no timeout.
- ADDR: bus_oe=1, bus_out={zero-pad, addr}, nLma=0 (MAR address latched at the end of the cycle) -> DATA.
- DATA: bus_oe=1, bus_out=data_q, nLmd=0 -> WRITE.
- WRITE: nLr=0, nCE=1, ram writes data_q at addr; byte_count increments at the end of the cycle.
  - If last_q=1 or addr==RAM_BYTES-1 -> DONE.
  - Otherwise addr increments and the state goes to WAIT_BYTE.
- DONE: one cycle with load_done=1, busy still 1 -> IDLE.
- Latency: 4 cycles per byte minimum (WAIT_BYTE accept, ADDR, DATA, WRITE).
- busy=1 in every state except IDLE.
  - cpu_rst_n is low throughout busy, so the CPU restarts at PC=0 on the first cycle after DONE.
- Boundaries:
  - start_load while busy: ignored.
  - ld_valid outside WAIT_BYTE: ignored; ld_ready=0 there.
  - Address wrap: never written beyond RAM_BYTES-1; an ld_last on that byte is consistent; the next loader byte waits for a new start_load.
  - start_load held high through DONE: a new load starts on the cycle after returning to IDLE.
  - rst_n asserted mid-load: immediate return to reset values; bytes already written stay in RAM (RAM is reset separately by its own rst_n).
- bus_oe=1 only in ADDR and DATA. CPU ctrl_in enables are masked there, so there is no bus contention.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - control-bit index constants (CP=14, EP=13, LP=12, NLMA=11, NLMD=10, NCE=9, NLR=8, NLI=7, NEI=6, NLA=5, EA=4, SUB=3, EU=2, NLB=1, NLO=0);
  - IDLE_WORD;
  - loader state encoding.
- One sub-module, `loader_ctrl_mux`: combinational selection of ctrl_out/bus_out per state. FSM and counters stay in `program_loader`.

Test Plan:
- Reset then idle: rst_n=0 -> ctrl_out=15'h0FE3, cpu_rst_n=0. Release with ctrl_in=15'h5A5A -> ctrl_out=15'h5A5A, busy=0, cpu_rst_n=1.
- 3-byte load, bytes 8'h1E, 8'h2F, 8'hE0, last on the third -> RAM[0..2] hold those bytes, byte_count=3, one load_done pulse, cpu_rst_n rises the cycle after DONE.
- Full load, 16 bytes with no ld_last -> auto DONE after addr 15. A 17th ld_valid is not accepted (ld_ready=0) until a new start_load.
- Stalled loader: ld_valid low for 20 cycles in WAIT_BYTE -> state holds, ctrl_out=IDLE_WORD, bus_oe=0.
- start_load pulsed during a load and rst_n asserted in the DATA state -> the pulse has no effect; reset returns all outputs to reset values within the same cycle, with no RAM write at the interrupted address.
- Per-state control words: ADDR only nLma low, DATA only nLmd low, WRITE only nLr low. bus_oe high in exactly ADDR and DATA.
